// File: rtl/ipv4_pkg.sv
// Shared constants, FSM state type and checksum helper for the IPv4 transmit encapsulator.
package ipv4_pkg;

  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_TOS        = 8'h00;
  localparam logic [15:0] IP_FLAGS_FRAG = 16'h4000;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam int          IP_HDR_LEN    = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_CSUM,
    ST_HDR,
    ST_PAY,
    ST_DROP
  } ipv4_state_e;

  // One's-complement add: carry out of bit 15 is folded straight back in.
  function automatic logic [16:0] csum_add(input logic [16:0] acc, input logic [15:0] word);
    logic [16:0] s;
    s = {1'b0, acc[15:0]} + {1'b0, word} + {16'b0, acc[16]};
    return {1'b0, s[15:0]} + {16'b0, s[16]};
  endfunction

endpackage

// File: rtl/ipv4_payload_buf.sv
// Datagram buffer: simple dual-port RAM with synchronous write and a registered read port.
module ipv4_payload_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ipv4_tx_encap.sv
// Buffers one UDP datagram, computes the IPv4 header checksum, then streams header + datagram.
// Stream handshake: a byte moves when ip_valid & ip_ready on a rising clk; ip_data/ip_last hold until then.
module ipv4_tx_encap
  import ipv4_pkg::*;
#(
  parameter logic [31:0] SRC_IP    = 32'hC0A8_0A02,
  parameter logic [31:0] DST_IP    = 32'hC0A8_0A01,
  parameter logic [7:0]  TTL       = 8'h40,
  parameter int          MAX_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  udp_data,
  input  logic        udp_valid,
  output logic [7:0]  ip_data,
  output logic        ip_valid,
  input  logic        ip_ready,
  output logic        ip_last,
  output logic        busy,
  output logic        drop_pulse,
  output ipv4_state_e dbg_state
);

  localparam int AW = $clog2(MAX_BYTES);
  localparam int CW = $clog2(MAX_BYTES + 1);

  // Reset asserts asynchronously and releases two clocks later, in step with clk.
  logic [1:0] rst_sync_q;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_ni = rst_sync_q[1];

  ipv4_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pay_idx_q, pay_idx_d;
  logic [3:0]    csum_idx_q, csum_idx_d;
  logic [4:0]    hdr_idx_q, hdr_idx_d;
  logic [16:0]   acc_q, acc_d;
  logic [15:0]   ident_q, ident_d;
  logic          udp_prev_q;
  logic [7:0]    ip_data_q, ip_data_d;
  logic          ip_valid_q, ip_valid_d;
  logic          ip_last_q, ip_last_d;
  logic          drop_q, drop_d;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rise;
  logic [15:0]   tot_len;
  logic [15:0]   hdr_w;

  ipv4_payload_buf #(.DEPTH(MAX_BYTES), .AW(AW)) u_buf (
    .clk      (clk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(udp_data),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  function automatic logic [15:0] hdr_word(input logic [3:0] idx, input logic [15:0] tot,
                                           input logic [15:0] id, input logic [15:0] cs);
    case (idx)
      4'd0:    return {IP_VER_IHL, IP_TOS};
      4'd1:    return tot;
      4'd2:    return id;
      4'd3:    return IP_FLAGS_FRAG;
      4'd4:    return {TTL, IP_PROTO_UDP};
      4'd5:    return cs;
      4'd6:    return SRC_IP[31:16];
      4'd7:    return SRC_IP[15:0];
      4'd8:    return DST_IP[31:16];
      4'd9:    return DST_IP[15:0];
      default: return 16'h0000;
    endcase
  endfunction

  assign rise    = udp_valid & ~udp_prev_q;
  assign tot_len = 16'(IP_HDR_LEN) + 16'(cnt_q);
  assign hdr_w   = hdr_word(hdr_idx_q[4:1], tot_len, ident_q, ~acc_q[15:0]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pay_idx_d  = pay_idx_q;
    csum_idx_d = csum_idx_q;
    hdr_idx_d  = hdr_idx_q;
    acc_d      = acc_q;
    ident_d    = ident_q;
    ip_data_d  = ip_data_q;
    ip_valid_d = ip_valid_q;
    ip_last_d  = ip_last_q;
    drop_d     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = cnt_q[AW-1:0];
    rd_addr    = pay_idx_q[AW-1:0];

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          cnt_d   = CW'(1);
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!udp_valid) begin
          state_d    = ST_CSUM;
          csum_idx_d = 4'd0;
          acc_d      = 17'd0;
        end else if (cnt_q == CW'(MAX_BYTES)) begin
          state_d = ST_DROP;
          drop_d  = 1'b1;
        end else begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CSUM: begin
        acc_d      = csum_add(acc_q, hdr_word(csum_idx_q, tot_len, ident_q, 16'h0000));
        csum_idx_d = csum_idx_q + 4'd1;
        if (csum_idx_q == 4'd9) begin
          state_d   = ST_HDR;
          hdr_idx_d = 5'd0;
          pay_idx_d = '0;
        end
      end
      ST_HDR: begin
        if (!ip_valid_q || ip_ready) begin
          ip_valid_d = 1'b1;
          ip_last_d  = 1'b0;
          ip_data_d  = hdr_idx_q[0] ? hdr_w[7:0] : hdr_w[15:8];
          hdr_idx_d  = hdr_idx_q + 5'd1;
          if (hdr_idx_q == 5'd19) state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (ip_valid_q && ip_ready && ip_last_q) begin
          ip_valid_d = 1'b0;
          ip_last_d  = 1'b0;
          ident_d    = ident_q + 16'd1;
          state_d    = ST_IDLE;
        end else if ((!ip_valid_q || ip_ready) && (pay_idx_q != cnt_q)) begin
          // rd_data already holds byte pay_idx; prefetch the one after so the next accept is ready.
          ip_valid_d = 1'b1;
          ip_data_d  = rd_data;
          ip_last_d  = (pay_idx_q == cnt_q - CW'(1));
          pay_idx_d  = pay_idx_q + CW'(1);
          rd_addr    = pay_idx_q[AW-1:0] + AW'(1);
        end
      end
      ST_DROP: begin
        if (!udp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new datagram arriving while a packet is in flight is discarded whole.
    if (rise && (state_q == ST_CSUM || state_q == ST_HDR || state_q == ST_PAY)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pay_idx_q  <= '0;
      csum_idx_q <= 4'd0;
      hdr_idx_q  <= 5'd0;
      acc_q      <= 17'd0;
      ident_q    <= 16'h0000;
      udp_prev_q <= 1'b0;
      ip_data_q  <= 8'h00;
      ip_valid_q <= 1'b0;
      ip_last_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pay_idx_q  <= pay_idx_d;
      csum_idx_q <= csum_idx_d;
      hdr_idx_q  <= hdr_idx_d;
      acc_q      <= acc_d;
      ident_q    <= ident_d;
      udp_prev_q <= udp_valid;
      ip_data_q  <= ip_data_d;
      ip_valid_q <= ip_valid_d;
      ip_last_q  <= ip_last_d;
      drop_q     <= drop_d;
    end
  end

  assign ip_data    = ip_data_q;
  assign ip_valid   = ip_valid_q;
  assign ip_last    = ip_last_q;
  assign drop_pulse = drop_q;
  assign busy       = (state_q == ST_CAPTURE) || (state_q == ST_CSUM) ||
                      (state_q == ST_HDR) || (state_q == ST_PAY);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ipv4_tx_encap.sv
// Bench for ipv4_tx_encap: datagrams in, IPv4 packets compared against a byte-level reference model.
module tb_ipv4_tx_encap;
  import ipv4_pkg::*;

  localparam logic [31:0] SRC_IP    = 32'hC0A8_0A02;
  localparam logic [31:0] DST_IP    = 32'hC0A8_0A01;
  localparam logic [7:0]  TTL       = 8'h40;
  localparam int          MAX_BYTES = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  udp_data = 8'h00;
  logic        udp_valid = 1'b0;
  logic        ip_ready;
  logic [7:0]  ip_data;
  logic        ip_valid, ip_last, busy, drop_pulse;
  ipv4_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rdy_rand = 1'b0;

  logic [7:0] dg_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] rx_all[$];
  logic [7:0] rx_cur[$];
  int         rx_lens[$];
  int         pkt_cnt = 0, drop_cnt = 0, stall_err = 0, valid_cycles = 0;
  int         rise_cyc = 0, fall_cyc = 0;
  logic [15:0] ident_m = 16'h0000;

  ipv4_tx_encap #(.SRC_IP(SRC_IP), .DST_IP(DST_IP), .TTL(TTL), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .udp_data(udp_data), .udp_valid(udp_valid),
    .ip_data(ip_data), .ip_valid(ip_valid), .ip_ready(ip_ready), .ip_last(ip_last),
    .busy(busy), .drop_pulse(drop_pulse), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ip_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ip_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic       prev_valid, stall_pend, st_l;
    logic [7:0] st_d;
    prev_valid = 0; stall_pend = 0; st_l = 0; st_d = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_cur.delete(); prev_valid = 0; stall_pend = 0;
      end else begin
        if (drop_pulse) drop_cnt++;
        if (ip_valid) valid_cycles++;
        if (ip_valid && !prev_valid) rise_cyc = cyc;
        if (stall_pend && (!ip_valid || ip_data !== st_d || ip_last !== st_l)) stall_err++;
        stall_pend = ip_valid && !ip_ready;
        st_d = ip_data; st_l = ip_last;
        if (ip_valid && ip_ready) begin
          rx_cur.push_back(ip_data);
          if (ip_last) begin
            foreach (rx_cur[i]) rx_all.push_back(rx_cur[i]);
            rx_lens.push_back(rx_cur.size());
            rx_cur.delete();
            pkt_cnt++;
          end
        end
        prev_valid = ip_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_dgram();
    foreach (dg_q[i]) begin
      @(posedge clk); #1;
      udp_valid = 1'b1; udp_data = dg_q[i];
    end
    @(posedge clk); #1;
    udp_valid = 1'b0; udp_data = 8'h00;
    fall_cyc = cyc + 1;
  endtask

  task automatic make_hello();
    logic [7:0] uh [8];
    string s;
    uh = '{8'h13, 8'h88, 8'h13, 8'h89, 8'h00, 8'h36, 8'h00, 8'h00};
    s = "Hello World";
    dg_q.delete();
    foreach (uh[i]) dg_q.push_back(uh[i]);
    for (int i = 0; i < s.len(); i++) dg_q.push_back(s[i]);
    while (dg_q.size() < 54) dg_q.push_back(8'h00);
  endtask

  task automatic make_random(input int len);
    dg_q.delete();
    repeat (len) dg_q.push_back(8'($urandom));
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int k;
    k = 0;
    while (pkt_cnt < n && k < budget) begin @(negedge clk); k++; end
  endtask

  task automatic pop_packet();
    int n;
    got_q.delete();
    if (rx_lens.size() > 0) begin
      n = rx_lens.pop_front();
      repeat (n) got_q.push_back(rx_all.pop_front());
    end
  endtask

  // ---------------- reference model ----------------
  task automatic build_expected();
    logic [15:0] w [10];
    int sum;
    w[0] = 16'h4500;
    w[1] = 16'(20 + dg_q.size());
    w[2] = ident_m;
    w[3] = 16'h4000;
    w[4] = {TTL, 8'h11};
    w[5] = 16'h0000;
    w[6] = SRC_IP[31:16]; w[7] = SRC_IP[15:0];
    w[8] = DST_IP[31:16]; w[9] = DST_IP[15:0];
    sum = 0;
    foreach (w[i]) sum += int'(w[i]);
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    w[5] = ~16'(sum);
    exp_q.delete();
    foreach (w[i]) begin exp_q.push_back(w[i][15:8]); exp_q.push_back(w[i][7:0]); end
    foreach (dg_q[i]) exp_q.push_back(dg_q[i]);
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i >= 0 && i < got_q.size()) ? got_q[i] : 8'h00;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'h00;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ip_data !== 8'h00)  begin errors++; $display("FAIL reset_ip_data: got %02h exp 00", ip_data); end
    checks++; if (ip_valid !== 1'b0)  begin errors++; $display("FAIL reset_ip_valid: got %b exp 0", ip_valid); end
    checks++; if (ip_last !== 1'b0)   begin errors++; $display("FAIL reset_ip_last: got %b exp 0", ip_last); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b exp 0", drop_pulse); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic();
    int p0, d;
    for (int rep = 0; rep < 2; rep++) begin
      p0 = pkt_cnt;
      make_hello(); build_expected(); send_dgram();
      wait_pkts(p0 + 1, 400);
      checks++; if (pkt_cnt !== p0 + 1) begin errors++; $display("FAIL basic_count%0d: got %0d exp %0d", rep, pkt_cnt, p0 + 1); end
      pop_packet();
      d = first_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL basic_bytes%0d: byte %0d got %02h exp %02h len %0d exp %0d", rep, d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
      checks++; if ({got_at(10), got_at(11)} !== (rep == 0 ? 16'hA54F : 16'hA54E)) begin errors++; $display("FAIL basic_csum%0d: got %02h%02h exp %04h", rep, got_at(10), got_at(11), rep == 0 ? 16'hA54F : 16'hA54E); end
      checks++; if ({got_at(4), got_at(5)} !== 16'(rep)) begin errors++; $display("FAIL basic_ident%0d: got %02h%02h exp %04h", rep, got_at(4), got_at(5), rep); end
      checks++; if (rise_cyc - fall_cyc !== 11) begin errors++; $display("FAIL basic_latency%0d: got %0d exp 11", rep, rise_cyc - fall_cyc); end
      ident_m++;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    int p0, d;
    p0 = pkt_cnt; stall_err = 0; rdy_rand = 1'b1;
    make_hello(); build_expected(); send_dgram();
    wait_pkts(p0 + 1, 1500);
    rdy_rand = 1'b0;
    checks++; if (pkt_cnt !== p0 + 1) begin errors++; $display("FAIL bp_count: got %0d exp %0d", pkt_cnt, p0 + 1); end
    pop_packet();
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL bp_bytes: byte %0d got %02h exp %02h len %0d exp %0d", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls exp 0", stall_err); end
    ident_m++;
  endtask

  task automatic test_overflow();
    int p0, d0, v0, d;
    p0 = pkt_cnt; d0 = drop_cnt; v0 = valid_cycles;
    make_random(MAX_BYTES + 1); send_dgram();
    repeat (40) @(negedge clk);
    checks++; if (drop_cnt !== d0 + 1) begin errors++; $display("FAIL ovf_drop: got %0d exp %0d", drop_cnt - d0, 1); end
    checks++; if (valid_cycles !== v0) begin errors++; $display("FAIL ovf_no_valid: got %0d valid cycles exp 0", valid_cycles - v0); end
    checks++; if (pkt_cnt !== p0) begin errors++; $display("FAIL ovf_no_pkt: got %0d exp %0d", pkt_cnt, p0); end
    make_random(MAX_BYTES); build_expected(); send_dgram();
    wait_pkts(p0 + 1, 400);
    pop_packet();
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL max_bytes: byte %0d got %02h exp %02h len %0d exp %0d", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
    checks++; if ({got_at(2), got_at(3)} !== 16'h0054) begin errors++; $display("FAIL max_totlen: got %02h%02h exp 0054", got_at(2), got_at(3)); end
    ident_m++;
  endtask

  task automatic test_drop_during_hdr();
    int p0, d0, k, d;
    p0 = pkt_cnt; d0 = drop_cnt;
    make_random(30); build_expected(); send_dgram();
    k = 0;
    while (!ip_valid && k < 50) begin @(negedge clk); k++; end
    checks++; if (ip_valid !== 1'b1) begin errors++; $display("FAIL hdr_start: got %b exp 1", ip_valid); end
    make_random(5); send_dgram();
    wait_pkts(p0 + 1, 400);
    checks++; if (drop_cnt !== d0 + 1) begin errors++; $display("FAIL hdr_drop: got %0d exp 1", drop_cnt - d0); end
    pop_packet();
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL hdr_inflight: byte %0d got %02h exp %02h len %0d exp %0d", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
    ident_m++;
    repeat (20) @(negedge clk);
    checks++; if (pkt_cnt !== p0 + 1) begin errors++; $display("FAIL hdr_no_extra: got %0d exp %0d", pkt_cnt, p0 + 1); end
    make_random(10); build_expected(); send_dgram();
    wait_pkts(p0 + 2, 400);
    pop_packet();
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL hdr_next: byte %0d got %02h exp %02h len %0d exp %0d", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
    ident_m++;
  endtask

  task automatic test_reset_mid();
    int p0, k, d;
    p0 = pkt_cnt;
    make_hello(); send_dgram();
    k = 0;
    while (rx_cur.size() < 50 && k < 200) begin @(negedge clk); k++; end
    #1; rst_n = 1'b0;
    #1;
    checks++; if (ip_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b exp 0", ip_valid); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_mid_busy: got %b exp 0", busy); end
    checks++; if (ip_last !== 1'b0)  begin errors++; $display("FAIL rst_mid_last: got %b exp 0", ip_last); end
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    checks++; if (pkt_cnt !== p0) begin errors++; $display("FAIL rst_mid_no_last: got %0d exp %0d", pkt_cnt, p0); end
    ident_m = 16'h0000;
    make_random(20); build_expected(); send_dgram();
    wait_pkts(p0 + 1, 400);
    pop_packet();
    d = first_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL rst_mid_next: byte %0d got %02h exp %02h len %0d exp %0d", d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
    checks++; if ({got_at(4), got_at(5)} !== 16'h0000) begin errors++; $display("FAIL rst_mid_ident: got %02h%02h exp 0000", got_at(4), got_at(5)); end
    ident_m++;
  endtask

  task automatic test_random();
    int p0, len, d;
    for (int it = 0; it < 8; it++) begin
      len = (it == 0) ? 1 : (it == 1) ? MAX_BYTES : int'($urandom_range(1, MAX_BYTES));
      rdy_rand = ($urandom_range(0, 1) == 1);
      p0 = pkt_cnt;
      make_random(len); build_expected(); send_dgram();
      wait_pkts(p0 + 1, 1500);
      rdy_rand = 1'b0;
      pop_packet();
      d = first_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL random%0d_len%0d: byte %0d got %02h exp %02h len %0d exp %0d", it, len, d, got_at(d), exp_at(d), got_q.size(), exp_q.size()); end
      ident_m++;
      repeat (2) @(negedge clk);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_drop_during_hdr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
